// File: rtl/shift_req_fifo.sv
// -----------------------------------------------------------------------------
// shift_req_fifo
//
// Request buffer placed directly in front of the 4-bit combinational barrel
// shifter. Requests {data, shift amount} arrive over a valid/ready handshake,
// are held in strict FIFO order, and the oldest one is presented on the
// shifter's X/shift inputs together with out_valid. The consumer samples the
// shifter result while out_valid is high and acknowledges with out_ready.
//
// Optional feature macro: SHIFT_REQ_COUNT_EN
//   defined   -> output port `count` exists and reports current occupancy
//   undefined -> no `count` port; all other behaviour identical
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears pointers/occupancy)
//   in_valid   in   producer has a request
//   in_ready   out  FIFO can accept (not full)
//   in_data    in   request data              [DATA_W]
//   in_shift   in   request shift amount      [SHIFT_W]
//   out_valid  out  head entry valid (not empty)
//   out_ready  in   consumer takes the head entry this cycle
//   X          out  head data to shifter, zero when empty   [DATA_W]
//   shift      out  head shift to shifter, zero when empty  [SHIFT_W]
//   count      out  occupancy (only with SHIFT_REQ_COUNT_EN) [$clog2(DEPTH)+1]
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shift_req_fifo #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 4,
    parameter int SHIFT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SHIFT_W-1:0]       in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        X,
`ifdef SHIFT_REQ_COUNT_EN
    output logic [SHIFT_W-1:0]       shift,
    output logic [$clog2(DEPTH):0]   count
`else
    output logic [SHIFT_W-1:0]       shift
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + SHIFT_W;

    // Storage is intentionally not reset; only pointers and occupancy are.
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             w_not_full;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    // Handshake qualification. A full FIFO refuses a push even when a pop
    // happens in the same cycle, so in_ready never depends on out_ready.
    always_comb begin
        w_not_full  = (r_occ != OCC_W'(DEPTH));
        w_not_empty = (r_occ != {OCC_W{1'b0}});
        w_push      = in_valid  && w_not_full;
        w_pop       = out_ready && w_not_empty;
        w_head      = r_mem[r_rd_ptr];
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= {OCC_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Request storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_data, in_shift};
        end
    end

    // Output decode: head entry when non-empty, forced zero otherwise so the
    // shifter sees a quiet input while nothing is pending.
    always_comb begin
        in_ready  = w_not_full;
        out_valid = w_not_empty;
        X         = {DATA_W{1'b0}};
        shift     = {SHIFT_W{1'b0}};
        if (w_not_empty) begin
            X     = w_head[ENT_W-1:SHIFT_W];
            shift = w_head[SHIFT_W-1:0];
        end else begin
            X     = {DATA_W{1'b0}};
            shift = {SHIFT_W{1'b0}};
        end
    end

`ifdef SHIFT_REQ_COUNT_EN
    // Occupancy export.
    always_comb begin
        count = r_occ;
    end
`endif

endmodule

// File: tb/tb_shift_req_fifo.sv
// -----------------------------------------------------------------------------
// tb_shift_req_fifo
//
// Directed bench for shift_req_fifo (DEPTH=4, DATA_W=4, SHIFT_W=2).
// A table of {inputs, expected post-edge outputs} records covers single
// request, fill/full, full with simultaneous pop, drain and idle-empty
// behaviour. Hand-written sequences cover continuous push+pop across pointer
// wrap and asynchronous reset in the middle of a stream.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_req_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_shift;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] X;
    logic [1:0] shift;
`ifdef SHIFT_REQ_COUNT_EN
    logic [2:0] count;
`endif

    int errors = 0;
    int checks = 0;

    shift_req_fifo #(.DEPTH(4), .DATA_W(4), .SHIFT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
`ifdef SHIFT_REQ_COUNT_EN
        .shift     (shift),
        .count     (count)
`else
        .shift     (shift)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic [1:0] s;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_x;
        logic [1:0] e_s;
        int         e_occ;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_ir, input logic e_ov,
                              input logic [3:0] e_x, input logic [1:0] e_s, input int e_occ);
        check({tag, ".in_ready"},  int'(in_ready),  int'(e_ir));
        check({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
        check({tag, ".X"},         int'(X),         int'(e_x));
        check({tag, ".shift"},     int'(shift),     int'(e_s));
`ifdef SHIFT_REQ_COUNT_EN
        check({tag, ".count"},     int'(count),     e_occ);
`else
        if (e_occ < 0) $display("note: negative occupancy in table");
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge act.
    task automatic drive(input logic iv, input logic [3:0] d, input logic [1:0] s,
                         input logic ordy);
        in_valid  = iv;
        in_data   = d;
        in_shift  = s;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Single request, held, then popped.
        vecs[0]  = '{1'b1, 4'hB, 2'b01, 1'b0, 1'b1, 1'b1, 4'hB, 2'b01, 1};
        vecs[1]  = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 4'hB, 2'b01, 1};
        vecs[2]  = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h0, 2'b00, 0};
        // Fill 1..4 (shift = data mod 4).
        vecs[3]  = '{1'b1, 4'h1, 2'd1, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, 1};
        vecs[4]  = '{1'b1, 4'h2, 2'd2, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, 2};
        vecs[5]  = '{1'b1, 4'h3, 2'd3, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, 3};
        vecs[6]  = '{1'b1, 4'h4, 2'd0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd1, 4};
        // Push while full: refused.
        vecs[7]  = '{1'b1, 4'h5, 2'd1, 1'b0, 1'b0, 1'b1, 4'h1, 2'd1, 4};
        // Full with push and pop together: pop only.
        vecs[8]  = '{1'b1, 4'h6, 2'd2, 1'b1, 1'b1, 1'b1, 4'h2, 2'd2, 3};
        // Drain remaining 3,4.
        vecs[9]  = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1, 4'h3, 2'd3, 2};
        vecs[10] = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1, 4'h4, 2'd0, 1};
        vecs[11] = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 0};
        // Empty with out_ready held for 5 cycles.
        for (int i = 12; i < 17; i++) begin
            vecs[i] = '{1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 0};
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_shift  = 2'b00;
        out_ready = 1'b0;
        #2;
        check_outs("reset", 1'b1, 1'b0, 4'h0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].s, vecs[i].ordy);
            check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                       vecs[i].e_x, vecs[i].e_s, vecs[i].e_occ);
        end

        // Continuous push+pop across pointer wrap: push 0..9, pop from cycle 2.
        for (int j = 0; j < 12; j++) begin
            if (j >= 2) begin
                check($sformatf("wrap%0d.X", j), int'(X), j - 2);
                check($sformatf("wrap%0d.shift", j), int'(shift), (j - 2) % 4);
                check($sformatf("wrap%0d.out_valid", j), int'(out_valid), 1);
            end
`ifdef SHIFT_REQ_COUNT_EN
            if (j >= 2 && j <= 10) check($sformatf("wrap%0d.count", j), int'(count), 2);
`endif
            drive(j < 10, 4'(j), 2'(j % 4), j >= 2);
        end
        check("wrap_end.out_valid", int'(out_valid), 0);
        check("wrap_end.X", int'(X), 0);

        // Asynchronous reset mid-stream with three entries held.
        drive(1'b1, 4'hA, 2'd2, 1'b0);
        drive(1'b1, 4'hC, 2'd3, 1'b0);
        drive(1'b1, 4'hE, 2'd1, 1'b0);
        check("pre_rst.X", int'(X), 10);
`ifdef SHIFT_REQ_COUNT_EN
        check("pre_rst.count", int'(count), 3);
`endif
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("midrst", 1'b1, 1'b0, 4'h0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h7, 2'd3, 1'b0);
        check_outs("post_rst", 1'b1, 1'b1, 4'h7, 2'd3, 1);
        drive(1'b0, 4'h0, 2'd0, 1'b1);
        check_outs("post_rst_pop", 1'b1, 1'b0, 4'h0, 2'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
